// File: rtl/wired_lsu_arbiter.sv
// Round-robin arbiter sharing one LSU request/response port between REQ_CNT requesters.
// Issued requests are tagged in an in-order FIFO so responses route back to their owner.
module wired_lsu_arbiter #(
  parameter int REQ_CNT     = 2,
  parameter int OUTSTANDING = 8,
  parameter int REQ_W       = 64,
  parameter int RESP_W      = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush_i,
  input  logic [REQ_CNT-1:0]                req_valid_i,
  output logic [REQ_CNT-1:0]                req_ready_o,
  input  logic [REQ_CNT-1:0][REQ_W-1:0]     req_i,
  output logic [REQ_CNT-1:0]                resp_valid_o,
  input  logic [REQ_CNT-1:0]                resp_ready_i,
  output logic [RESP_W-1:0]                 resp_o,
  output logic                              lsu_req_valid_o,
  input  logic                              lsu_req_ready_i,
  output logic [REQ_W-1:0]                  lsu_req_o,
  input  logic                              lsu_resp_valid_i,
  output logic                              lsu_resp_ready_o,
  input  logic [RESP_W-1:0]                 lsu_resp_i,
  output logic [$clog2(OUTSTANDING):0]      outstanding_o,
  output logic                              busy_o
);

  localparam int SW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, DRAIN} state_e;

  state_e              state_q;
  logic                slot_valid_q;
  logic [REQ_W-1:0]    slot_q;
  logic [SW-1:0]       slot_src_q;
  logic [SW-1:0]       rr_q, rr_d;
  logic [SW-1:0]       tag_mem [OUTSTANDING];
  logic [PW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q, drop_q, drop_d;

  logic [SW-1:0]       winner;
  logic                any_valid, can_accept, accept;
  logic                lsu_fire, resp_pop, drain_pop, fifo_ne;
  logic [SW-1:0]       head;
  logic [CW:0]         used;

  always_comb begin
    int idx;
    int nxt;
    logic [SW-1:0] idx_l;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    idx_l     = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= REQ_CNT) idx = idx - REQ_CNT;
      idx_l = SW'(idx);
      if (!any_valid && req_valid_i[idx_l]) begin
        any_valid = 1'b1;
        winner    = idx_l;
      end
    end
    nxt = int'(winner) + 1;
    if (nxt >= REQ_CNT) nxt = 0;
    rr_d = SW'(nxt);
  end

  // Credit check ignores a same-cycle response pop so the accept path stays short.
  assign used       = {1'b0, cnt_q} + {{CW{1'b0}}, slot_valid_q};
  assign can_accept = (state_q == RUN) && !flush_i && (!slot_valid_q || lsu_req_ready_i)
                      && (used < (CW+1)'(OUTSTANDING));
  assign accept     = any_valid && can_accept;

  always_comb begin
    req_ready_o = '0;
    if (any_valid) req_ready_o[winner] = can_accept;
  end

  assign lsu_req_valid_o = slot_valid_q;
  assign lsu_req_o       = slot_q;
  assign lsu_fire        = slot_valid_q && lsu_req_ready_i;

  assign fifo_ne = (cnt_q != '0);
  assign head    = tag_mem[rd_q];

  // Responses with no recorded owner (empty FIFO or draining) are swallowed.
  always_comb begin
    resp_valid_o     = '0;
    lsu_resp_ready_o = 1'b1;
    if (state_q == RUN && fifo_ne) begin
      resp_valid_o[head] = lsu_resp_valid_i;
      lsu_resp_ready_o   = resp_ready_i[head];
    end
  end

  assign resp_o    = lsu_resp_i;
  assign resp_pop  = (state_q == RUN) && fifo_ne && lsu_resp_valid_i && resp_ready_i[head];
  assign drain_pop = (state_q == DRAIN) && lsu_resp_valid_i;
  assign drop_d    = ((state_q == DRAIN) ? drop_q : cnt_q) + CW'(lsu_fire)
                     - CW'(resp_pop || drain_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      slot_valid_q <= 1'b0;
      slot_q       <= '0;
      slot_src_q   <= '0;
      rr_q         <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      drop_q       <= '0;
    end else begin
      if (accept) rr_q <= rr_d;

      if (flush_i) begin
        slot_valid_q <= 1'b0;
      end else if (accept) begin
        slot_valid_q <= 1'b1;
        slot_q       <= req_i[winner];
        slot_src_q   <= winner;
      end else if (lsu_fire) begin
        slot_valid_q <= 1'b0;
      end

      if (flush_i) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (lsu_fire) wr_q <= wr_q + PW'(1);
        if (resp_pop) rd_q <= rd_q + PW'(1);
        cnt_q <= cnt_q + CW'(lsu_fire) - CW'(resp_pop);
      end

      if (flush_i) begin
        drop_q  <= drop_d;
        state_q <= (drop_d != '0) ? DRAIN : RUN;
      end else if (drain_pop) begin
        drop_q <= drop_q - CW'(1);
        if (drop_q == CW'(1)) state_q <= RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (lsu_fire) tag_mem[wr_q] <= slot_src_q;
  end

  assign outstanding_o = cnt_q;
  assign busy_o        = slot_valid_q || fifo_ne || (state_q == DRAIN);

endmodule

// File: tb/tb_wired_lsu_arbiter.sv
// Directed bench for wired_lsu_arbiter: scoreboard of expected LSU payloads and response owners.
module tb_wired_lsu_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [1:0][15:0] req_data;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready = 2'b11;
  logic [15:0]      resp_data;
  logic             lsu_req_valid;
  logic             lsu_req_ready = 1'b0;
  logic [15:0]      lsu_req;
  logic             lsu_resp_valid = 1'b0;
  logic             lsu_resp_ready;
  logic [15:0]      lsu_resp = 16'h0;
  logic [3:0]       outstanding;
  logic             busy;

  always #5 clk = ~clk;

  wired_lsu_arbiter #(.REQ_CNT(2), .OUTSTANDING(8), .REQ_W(16), .RESP_W(16)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_i(req_data),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_o(resp_data),
    .lsu_req_valid_o(lsu_req_valid), .lsu_req_ready_i(lsu_req_ready), .lsu_req_o(lsu_req),
    .lsu_resp_valid_i(lsu_resp_valid), .lsu_resp_ready_o(lsu_resp_ready), .lsu_resp_i(lsu_resp),
    .outstanding_o(outstanding), .busy_o(busy)
  );

  typedef struct packed { logic src; logic [15:0] data; } ent_t;

  ent_t exp_req[$];
  int   own_q[$];
  int   grants[$];
  int   tests = 0, fails = 0;
  int   drain_left = 0, max_out = 0;
  logic [1:0] acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called mid-cycle with inputs settled: checks fires/responses and records accepts.
  task automatic monitor();
    ent_t e;
    logic o;
    acc = 2'b00;
    if (lsu_req_valid && lsu_req_ready) begin
      if (exp_req.size() == 0) chk("unexpected_fire", 32'd1, 32'd0);
      else begin
        e = exp_req.pop_front();
        chk("lsu_req_payload", 32'(lsu_req), 32'(e.data));
        own_q.push_back(int'(e.src));
      end
    end
    if (lsu_resp_valid) begin
      chk("resp_broadcast", 32'(resp_data), 32'(lsu_resp));
      if (drain_left > 0) begin
        chk("drain_resp_valid", 32'(resp_valid), 32'd0);
        chk("drain_resp_ready", 32'(lsu_resp_ready), 32'd1);
        drain_left--;
      end else if (own_q.size() > 0) begin
        o = own_q[0][0];
        chk("resp_route", 32'(resp_valid), 32'(2'b01 << o));
        chk("resp_ready_route", 32'(lsu_resp_ready), 32'(resp_ready[o]));
        if (resp_ready[o]) void'(own_q.pop_front());
      end
    end
    for (int r = 0; r < 2; r++) begin
      logic rb;
      rb = r[0];
      if (req_valid[rb] && req_ready[rb]) begin
        e.src  = rb;
        e.data = req_data[rb];
        exp_req.push_back(e);
        grants.push_back(r);
        acc[rb] = 1'b1;
      end
    end
    if (int'(outstanding) > max_out) max_out = int'(outstanding);
  endtask

  task automatic cyc();
    #2;
    monitor();
    @(posedge clk);
    #1;
    if (acc[0]) req_data[0] = req_data[0] + 16'd1;
    if (acc[1]) req_data[1] = req_data[1] + 16'd1;
  endtask

  task automatic quiesce();
    req_valid     = 2'b00;
    lsu_req_ready = 1'b1;
    resp_ready    = 2'b11;
    flush         = 1'b0;
    for (int i = 0; i < 40 && (own_q.size() != 0 || exp_req.size() != 0 || drain_left != 0
                               || outstanding != 4'd0); i++) begin
      lsu_resp_valid = (own_q.size() != 0) || (drain_left != 0);
      lsu_resp       = 16'hB000 + 16'(i);
      cyc();
    end
    lsu_resp_valid = 1'b0;
    #1;
    chk("quiesce_outstanding", 32'(outstanding), 32'd0);
    chk("quiesce_queues", 32'(own_q.size() + exp_req.size()), 32'd0);
    chk("quiesce_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    req_data[0] = 16'h1000;
    req_data[1] = 16'h2000;

    // Reset state
    #3;
    chk("rst_lsu_valid", 32'(lsu_req_valid), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_ready", 32'(lsu_resp_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Round-robin fairness with 1-cycle response return
    req_valid = 2'b11; lsu_req_ready = 1'b1; grants.delete(); max_out = 0;
    for (int i = 0; i < 12; i++) begin
      lsu_resp_valid = (own_q.size() != 0);
      lsu_resp       = 16'hA000 + 16'(i);
      cyc();
    end
    chk("rr_grant_count", 32'(grants.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++)
      if (i < grants.size()) chk("rr_grant", 32'(grants[i]), 32'(i % 2));
    chk("rr_max_outstanding", 32'(max_out <= 2), 32'd1);
    quiesce();

    // Slot stability under LSU backpressure
    req_valid = 2'b01; lsu_req_ready = 1'b0; req_data[0] = 16'h5A5A;
    #1 chk("stall_first_ready", 32'(req_ready), 32'b01);
    cyc();
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", 32'(lsu_req_valid), 32'd1);
      chk("stall_payload", 32'(lsu_req), 32'h5A5A);
      chk("stall_ready_blocked", 32'(req_ready), 32'd0);
      cyc();
    end
    req_valid = 2'b00; lsu_req_ready = 1'b1;
    cyc();
    #1;
    chk("stall_fired_out", 32'(outstanding), 32'd1);
    chk("stall_slot_clear", 32'(lsu_req_valid), 32'd0);
    quiesce();

    // Credit limit at OUTSTANDING=8
    req_valid = 2'b01; lsu_req_ready = 1'b1; lsu_resp_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1 chk("credit_accept", 32'(req_ready), 32'b01);
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      #1 chk("credit_blocked", 32'(req_ready), 32'd0);
      cyc();
    end
    chk("credit_out8", 32'(outstanding), 32'd8);
    lsu_resp_valid = 1'b1; lsu_resp = 16'hC001;
    #1 chk("credit_no_bypass", 32'(req_ready), 32'd0);
    cyc();
    lsu_resp_valid = 1'b0;
    #1 chk("credit_reenabled", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    cyc();
    quiesce();

    // Flush with 3 in flight plus a slot firing in the flush cycle
    req_valid = 2'b01; lsu_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    req_valid = 2'b00; flush = 1'b1;
    #1;
    chk("flush_pre_out", 32'(outstanding), 32'd3);
    chk("flush_pre_slot", 32'(lsu_req_valid), 32'd1);
    cyc();
    flush = 1'b0;
    drain_left = drain_left + own_q.size();
    own_q.delete(); exp_req.delete();
    req_valid = 2'b01;
    #1;
    chk("flush_out0", 32'(outstanding), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    chk("flush_lsu_valid", 32'(lsu_req_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      lsu_resp_valid = 1'b1; lsu_resp = 16'hD000 + 16'(i);
      #1 chk("drain_req_blocked", 32'(req_ready), 32'd0);
      cyc();
    end
    lsu_resp_valid = 1'b0;
    #1 chk("drain_back_to_run", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    cyc();
    quiesce();

    // Flush during DRAIN coinciding with a drained response
    req_valid = 2'b01; lsu_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    req_valid = 2'b00;
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drain_left = drain_left + own_q.size();
    own_q.delete(); exp_req.delete();
    lsu_resp_valid = 1'b1;
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drain_left = drain_left + own_q.size();
    own_q.delete(); exp_req.delete();
    req_valid = 2'b01; lsu_resp_valid = 1'b0;
    #1;
    chk("redrain_blocked", 32'(req_ready), 32'd0);
    chk("redrain_busy", 32'(busy), 32'd1);
    cyc();
    lsu_resp_valid = 1'b1;
    #1 chk("redrain_last_blocked", 32'(req_ready), 32'd0);
    cyc();
    lsu_resp_valid = 1'b0;
    #1 chk("redrain_run", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    cyc();
    quiesce();

    // Async reset mid-burst with slot valid and 5 in flight
    req_valid = 2'b01; lsu_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    lsu_req_ready = 1'b0; req_valid = 2'b00;
    #1;
    chk("areset_pre_out", 32'(outstanding), 32'd5);
    chk("areset_pre_slot", 32'(lsu_req_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("areset_lsu_valid", 32'(lsu_req_valid), 32'd0);
    chk("areset_out", 32'(outstanding), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    own_q.delete(); exp_req.delete(); drain_left = 0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    req_valid = 2'b01; lsu_req_ready = 1'b1;
    #1 chk("areset_run", 32'(req_ready), 32'b01);
    cyc();
    quiesce();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wired_lsu_arbiter.md
Name: wired_lsu_arbiter

Overview:
- Shares the single LSU request/response port between REQ_CNT requesters, e.g. port 0 = LSU issue queue, port 1 = commit-stage uncached/cacop sequencer.
- Grants round-robin into a one-entry registered output slot.
- Records each issued request's source in an in-order tag FIFO and routes in-order LSU responses back to the originating requester.
- On flush, discards in-flight responses through a drain state machine.

Parameters:
- REQ_CNT, 2, number of requesters (≥2).
- OUTSTANDING, 8, max requests issued to LSU and not yet responded, plus the slot (power of 2).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- flush_i  input  1  backend flush.
- req_valid_i  input  REQ_CNT  per-requester request valid.
- req_ready_o  output  REQ_CNT  per-requester accept.
- req_i  input  REQ_CNT×$bits(iq_lsu_req_t)  per-requester request payload.
- resp_valid_o  output  REQ_CNT  response valid, one-hot to owner.
- resp_ready_i  input  REQ_CNT  per-requester response ready.
- resp_o  output  $bits(iq_lsu_resp_t)  response payload, broadcast = lsu_resp_i.
- lsu_req_valid_o  output  1  to LSU.
- lsu_req_ready_i  input  1  from LSU.
- lsu_req_o  output  $bits(iq_lsu_req_t)  slot payload.
- lsu_resp_valid_i  input  1  from LSU.
- lsu_resp_ready_o  output  1  to LSU.
- lsu_resp_i  input  $bits(iq_lsu_resp_t)  LSU response.
- outstanding_o  output  $clog2(OUTSTANDING)+1  tag-FIFO occupancy.
- busy_o  output  1  slot valid, FIFO non-empty, or state DRAIN.

Behaviour:
- Reset (async, rst=1):
  - state=RUN; slot empty (lsu_req_valid_o=0); tag FIFO empty (outstanding_o=0); drop_cnt=0; RR pointer=0.
  - All valid/ready outputs 0 except where derived combinationally below.
- States:
  - RUN: normal operation.
  - DRAIN: discard responses whose requests preceded a flush.
- can_accept = state==RUN & !flush_i & (!slot_valid | lsu_req_ready_i) & (fifo_cnt + slot_valid < OUTSTANDING).
  - The sum ignores same-cycle response pops; no bypass.
- Arbitration:
  - Winner = first valid requester at or after the RR pointer, wrapping modulo REQ_CNT.
  - req_ready_o[winner] = can_accept; all other bits 0.
  - On accept: slot <= req_i[winner], slot_src <= winner, slot_valid <= 1, RR pointer <= winner+1 mod REQ_CNT.
  - If no requester is valid, the pointer is unchanged.
- Latency: request handshake → lsu_req_valid_o high at the next cycle. Back-to-back throughput is 1/cycle while lsu_req_ready_i=1 and credits are available.
- Output slot:
  - lsu_req_valid_o = slot_valid; lsu_req_o/slot_src are stable while valid & !ready.
  - On lsu fire: push slot_src into the tag FIFO. The slot clears unless a new accept occurs in the same cycle.
- Response routing, RUN with FIFO non-empty:
  - resp_valid_o[head] = lsu_resp_valid_i; lsu_resp_ready_o = resp_ready_i[head].
  - Handshake pops the head.
  - Push and pop in the same cycle leave the count unchanged.
- Response with FIFO empty in RUN is a protocol violation: lsu_resp_ready_o=1, response dropped, no resp_valid_o.
- Flush (flush_i=1, any state):
  - Slot cleared; no new accepts that cycle.
  - A slot that fires to LSU in the flush cycle counts as in flight.
  - drop_cnt <= fifo_cnt + lsu_fire - resp_pop_this_cycle; FIFO cleared.
  - Next state = DRAIN if that value >0, else RUN.
  - A flush during DRAIN recomputes drop_cnt the same way; FIFO is already empty, so drop_cnt is kept minus any pop.
- DRAIN:
  - lsu_resp_ready_o=1; resp_valid_o=0; req_ready_o=0; lsu_req_valid_o=0.
  - Each lsu response decrements drop_cnt; at 1→0 go to RUN. Accepts are allowed from the following cycle.
- RR pointer is not reset by flush.

Test Plan:
- Round-robin fairness: both requesters valid continuously, lsu_req_ready_i=1, responses returned 1 cycle after each issue. Required: grants alternate 0,1,0,1; outstanding_o never exceeds 2; each response goes only to its owner's resp_valid_o.
- Slot stability: req0 accepted, lsu_req_ready_i held 0 for 5 cycles. Required: lsu_req_o stable and lsu_req_valid_o=1 throughout; req_ready_o=0 for all requesters; 1 fire when ready rises.
- Credit limit: OUTSTANDING=8, issue 8 requests with no responses. Required: 8th accept leaves fifo_cnt+slot=8 and req_ready_o stays 0. One response pop re-enables accept on the following cycle.
- Flush drain: 3 responses outstanding, then flush_i for 1 cycle with the slot firing simultaneously. Required: drop_cnt=4, state DRAIN, next 4 lsu responses consumed with resp_valid_o=0, RUN on the cycle after the 4th.
- Flush during DRAIN: drop_cnt=2, flush again coinciding with a response pop. Required: drop_cnt=1, still DRAIN.
- Async reset mid-burst: assert rst between clock edges with slot valid and FIFO=5. Required: lsu_req_valid_o=0, outstanding_o=0, busy_o=0 immediately; RUN after deassert.
